// File: rtl/mwtxhdr_pkg.sv
// Shared definitions for the mwtxhdrstrip header-strip stage.
// Holds the FSM state encoding and a width helper for the header word counter.
package mwtxhdr_pkg;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_PAY  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mwtxhdr_outreg.sv
// Single-entry valid/ready output register carrying {eop, data}.
// load is only asserted by the parent when the slot is empty or draining this cycle.
module mwtxhdr_outreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_eop,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         eop
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      eop   <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      eop   <= load_eop;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mwtxhdrstrip.sv
// Header-strip stage: captures HDR_BYTES leading words per packet, forwards the payload.
// Optional statistics counters are built when TXHDR_STATS_EN is defined.
// Handshake: a word moves on valid & ready; out_valid holds data/eop stable until out_ready.
module mwtxhdrstrip
  import mwtxhdr_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int HDR_BYTES = 4,
  parameter int MAX_PAY   = 1500,
  parameter int CNTWIDTH  = 16
) (
  input  logic                           txclk,
  input  logic                           txrst,
  input  logic [DATAWIDTH-1:0]           in_data,
  input  logic                           in_valid,
  input  logic                           in_eop,
  output logic                           in_ready,
  output logic [DATAWIDTH-1:0]           out_data,
  output logic                           out_valid,
  output logic                           out_eop,
  input  logic                           out_ready,
  output logic [HDR_BYTES*DATAWIDTH-1:0] out_hdr,
  output logic                           out_hdr_valid,
  output logic                           runt_err,
  output logic                           oversize_err,
  output logic [31:0]                    pkt_cnt,
  output logic [31:0]                    runt_cnt,
  output logic [31:0]                    oversize_cnt
);

  localparam int HW  = HDR_BYTES * DATAWIDTH;
  localparam int HCW = (clog2(HDR_BYTES) < 1) ? 1 : clog2(HDR_BYTES);

  state_t                state, state_next;
  logic [HCW-1:0]        hdr_cnt;
  logic [CNTWIDTH-1:0]   pay_cnt;
  logic [HW-1:0]         hdr_word;
  logic                  accept, hdr_last, pay_last, load, load_eop;

  assign hdr_last = (hdr_cnt == HCW'(HDR_BYTES - 1));
  assign pay_last = (pay_cnt == CNTWIDTH'(MAX_PAY - 1));

  always_ff @(posedge txclk or posedge txrst) begin
    if (txrst) state <= S_HDR;
    else       state <= state_next;
  end

  // In S_HDR the output must be empty so the header never changes under a draining packet.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    load       = 1'b0;
    load_eop   = 1'b0;
    case (state)
      S_HDR:  in_ready = !out_valid;
      S_PAY:  in_ready = !out_valid || out_ready;
      S_DROP: in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
    if (txrst) in_ready = 1'b0;
    accept = in_valid && in_ready;
    case (state)
      S_HDR: begin
        if (accept && !in_eop && hdr_last) state_next = S_PAY;
      end
      S_PAY: begin
        if (accept) begin
          load     = 1'b1;
          load_eop = in_eop || pay_last;
          if (in_eop)        state_next = S_HDR;
          else if (pay_last) state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (accept && in_eop) state_next = S_HDR;
      end
      default: state_next = S_HDR;
    endcase
  end

  generate
    if (HDR_BYTES > 1) begin : g_shadow
      logic [(HDR_BYTES-1)*DATAWIDTH-1:0] shadow;
      assign hdr_word = {shadow, in_data};
      always_ff @(posedge txclk or posedge txrst) begin
        if (txrst)                          shadow <= '0;
        else if (accept && state == S_HDR) shadow <= hdr_word[(HDR_BYTES-1)*DATAWIDTH-1:0];
      end
    end else begin : g_noshadow
      assign hdr_word = in_data;
    end
  endgenerate

  always_ff @(posedge txclk or posedge txrst) begin
    if (txrst) begin
      hdr_cnt       <= '0;
      pay_cnt       <= '0;
      out_hdr       <= '0;
      out_hdr_valid <= 1'b0;
      runt_err      <= 1'b0;
      oversize_err  <= 1'b0;
    end else begin
      out_hdr_valid <= 1'b0;
      runt_err      <= 1'b0;
      oversize_err  <= 1'b0;
      if (accept) begin
        case (state)
          S_HDR: begin
            if (in_eop) begin
              runt_err <= 1'b1;
              hdr_cnt  <= '0;
            end else if (hdr_last) begin
              out_hdr       <= hdr_word;
              out_hdr_valid <= 1'b1;
              hdr_cnt       <= '0;
              pay_cnt       <= '0;
            end else begin
              hdr_cnt <= hdr_cnt + 1'b1;
            end
          end
          S_PAY: begin
            pay_cnt <= pay_cnt + 1'b1;
            if (!in_eop && pay_last) oversize_err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  mwtxhdr_outreg #(.W(DATAWIDTH)) u_outreg (
    .clk       (txclk),
    .rst       (txrst),
    .load      (load),
    .load_data (in_data),
    .load_eop  (load_eop),
    .ready     (out_ready),
    .valid     (out_valid),
    .data      (out_data),
    .eop       (out_eop)
  );

`ifdef TXHDR_STATS_EN
  logic pkt_done;
  assign pkt_done = accept && (state == S_PAY) && in_eop;

  // Counters saturate so long-running links never wrap back to small values.
  always_ff @(posedge txclk or posedge txrst) begin
    if (txrst) begin
      pkt_cnt      <= '0;
      runt_cnt     <= '0;
      oversize_cnt <= '0;
    end else begin
      if (pkt_done && pkt_cnt != 32'hFFFF_FFFF)         pkt_cnt      <= pkt_cnt + 32'd1;
      if (runt_err && runt_cnt != 32'hFFFF_FFFF)         runt_cnt     <= runt_cnt + 32'd1;
      if (oversize_err && oversize_cnt != 32'hFFFF_FFFF) oversize_cnt <= oversize_cnt + 32'd1;
    end
  end
`else
  assign pkt_cnt      = '0;
  assign runt_cnt     = '0;
  assign oversize_cnt = '0;
`endif

endmodule
